led_fade_driver: RTL and testbench

- Downstream stage of the LED blinker: takes the blinker's binary LED level and drives the physical LED pin.
- Converts each hard on/off edge into a linear brightness fade using a PWM carrier and a duty ramp.
- Output feeds the board LED pin directly. Active-low by default, matching the board LEDs and the blinker's reset-off level.

---
 rtl/led_fade_driver.sv | 107 ++++++++++
 tb/tb_led_fade_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// led_fade_driver: turns the blinker's hard on/off LED level into a linear
// brightness fade on the board LED pin.
//
// Each on/off edge on led_i starts a duty ramp. The duty moves by one LSB
// every STEP_DIV clocks. A PWM carrier with a period of 2^PWM_W clocks drives
// the pin from that duty.
//
// Ports:
//   clk     - system clock
//   rstn    - asynchronous, active-low reset
//   led_i   - requested LED level from the blinker (polarity per ACTIVE_LOW)
//   pwm_o   - registered PWM drive to the LED pin (polarity per ACTIVE_LOW)
//   duty_o  - current ramp duty, 0 = dark, 2^PWM_W-1 = full
//   state_o - FSM state: 0 OFF, 1 RAMP_UP, 2 ON, 3 RAMP_DOWN
module led_fade_driver #(
  parameter int PWM_W      = 8,
  parameter int STEP_DIV   = 10000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             led_i,
  output logic             pwm_o,
  output logic [PWM_W-1:0] duty_o,
  output logic [1:0]       state_o
);

  localparam int              SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_W-1:0] DMAX     = '1;
  localparam logic [SW-1:0]   STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic            AL        = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PWM_W-1:0] duty, duty_nxt, duty_act, pwm_cnt;
  logic [SW-1:0]    step_cnt, step_nxt;
  logic             req, lit;

  // Lit request: led_i at its active level. Same clock domain, no synchroniser.
  assign req = led_i ^ AL;

  // Next state. A reversal is checked before the endpoint, so a request flip
  // in the same cycle the ramp reaches its end turns the ramp around.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:   if (req) state_nxt = S_UP;
      S_UP:    if (!req) state_nxt = S_DOWN;
               else if (duty == DMAX) state_nxt = S_ON;
      S_ON:    if (!req) state_nxt = S_DOWN;
      S_DOWN:  if (req) state_nxt = S_UP;
               else if (duty == '0) state_nxt = S_OFF;
      default: state_nxt = S_OFF;
    endcase
  end

  // Step timer and duty ramp. The timer runs only while the FSM stays in a
  // ramp state. Any state change restarts it from 0. A reversal therefore
  // continues from the current duty and takes its first step a full
  // STEP_DIV clocks later.
  always_comb begin
    step_nxt = '0;
    duty_nxt = duty;
    if ((state_nxt == state) && ((state == S_UP) || (state == S_DOWN))) begin
      if (step_cnt == STEP_LAST) begin
        if ((state == S_UP) && (duty != DMAX)) duty_nxt = duty + 1'b1;
        if ((state == S_DOWN) && (duty != '0)) duty_nxt = duty - 1'b1;
      end else begin
        step_nxt = step_cnt + 1'b1;
      end
    end
  end

  // Full-scale duty is solid on. Without this term the comparison would
  // leave one dark clock in each period.
  assign lit = (duty_act == DMAX) || (pwm_cnt < duty_act);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_OFF;
      duty     <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      duty_act <= '0;
      pwm_o    <= AL;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      step_cnt <= step_nxt;
      pwm_cnt  <= pwm_cnt + 1'b1;
      // Take the new duty only at the end of a period, so a period never
      // mixes two duty values.
      if (pwm_cnt == DMAX) duty_act <= duty;
      pwm_o    <= lit ^ AL;
    end
  end

  assign duty_o  = duty;
  assign state_o = state;

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver with PWM_W=4, STEP_DIV=4, ACTIVE_LOW=1.
// The driver applies led_i on the falling edge. It then advances a behavioural
// model and queues the outputs expected after the next rising edge. A monitor
// pops one entry after every rising edge and compares it with the DUT outputs.
module tb_led_fade_driver;
  localparam int PW = 4;
  localparam int SD = 4;
  localparam int DM = 15;

  logic          clk = 1'b0;
  logic          rstn;
  logic          led_i;
  logic          pwm_o;
  logic [PW-1:0] duty_o;
  logic [1:0]    state_o;

  led_fade_driver #(.PWM_W(PW), .STEP_DIV(SD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rstn(rstn), .led_i(led_i),
    .pwm_o(pwm_o), .duty_o(duty_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [6:0] exp_q[$];

  // Model: state (0 off, 1 up, 2 on, 3 down), brightness and clocks spent in
  // the current ramp. The carrier is a cycle counter modulo 16, with the
  // duty latched at each period boundary.
  int m_state, m_duty, m_age, m_cnt, m_dact, m_pwm;

  function automatic void model_reset();
    m_state = 0; m_duty = 0; m_age = 0; m_cnt = 0; m_dact = 0; m_pwm = 1;
  endfunction

  function automatic void model_step(input logic l);
    bit req;
    int nxt_pwm, dir;
    req     = (l == 1'b0);
    nxt_pwm = ((m_dact == DM) || (m_cnt < m_dact)) ? 0 : 1;
    if (m_cnt == DM) m_dact = m_duty;
    m_cnt = (m_cnt + 1) % (DM + 1);
    dir = 0;
    case (m_state)
      0: if (req) begin m_state = 1; m_age = 0; end
      1: if (!req) begin m_state = 3; m_age = 0; end
         else if (m_duty == DM) begin m_state = 2; m_age = 0; end
         else dir = 1;
      2: if (!req) begin m_state = 3; m_age = 0; end
      default: if (req) begin m_state = 1; m_age = 0; end
         else if (m_duty == 0) begin m_state = 0; m_age = 0; end
         else dir = -1;
    endcase
    if (dir != 0) begin
      m_age++;
      if (m_age % SD == 0) begin
        m_duty += dir;
        if (m_duty > DM) m_duty = DM;
        if (m_duty < 0) m_duty = 0;
      end
    end
    m_pwm = nxt_pwm;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus. Releasing reset here keeps every rising edge
  // after reset covered by the model.
  task automatic step(input logic l);
    @(negedge clk);
    rstn  = 1'b1;
    led_i = l;
    model_step(l);
    exp_q.push_back({1'(m_pwm), 4'(m_duty), 2'(m_state)});
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check({tag, "_pwm"},   int'(pwm_o),   1);
    check({tag, "_duty"},  int'(duty_o),  0);
    check({tag, "_state"}, int'(state_o), 0);
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin : mon
    logic [6:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pwm_o",   int'(pwm_o),   int'(e[6]));
      check("duty_o",  int'(duty_o),  int'(e[5:2]));
      check("state_o", int'(state_o), int'(e[1:0]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, lows, n;
    logic l;
    rstn  = 1'b1;
    led_i = 1'b1;
    model_reset();
    #1 rstn = 1'b0;
    #1;
    check("rst_pwm",   int'(pwm_o),   1);
    check("rst_duty",  int'(duty_o),  0);
    check("rst_state", int'(state_o), 0);

    // Fade up to ON, then hold
    g = 0;
    step(1'b0);
    while (m_state != 2 && g < 100) begin step(1'b0); g++; end
    check("fade_up_reach_on", m_state, 2);
    repeat (40) step(1'b0);

    // Fade down to OFF, then hold
    g = 0;
    while (m_state != 0 && g < 100) begin step(1'b1); g++; end
    repeat (40) step(1'b1);

    // Park the duty at 5 by reversing faster than the step timer
    g = 0;
    step(1'b0);
    while (!(m_state == 1 && m_duty == 5) && g < 100) begin step(1'b0); g++; end
    for (int i = 0; i < 40; i++) step(((i / 2) % 2 == 0) ? 1'b1 : 1'b0);
    lows = 0;
    for (int i = 40; i < 56; i++) begin
      step(((i / 2) % 2 == 0) ? 1'b1 : 1'b0);
      @(posedge clk);
      #2 if (pwm_o == 1'b0) lows++;
    end
    check("pwm_lows_duty5", lows, 5);
    check("duty_held5", int'(duty_o), 5);

    // Return to OFF
    g = 0;
    while (m_state != 0 && g < 100) begin step(1'b1); g++; end

    // Reverse at duty 7 and ramp back down to OFF
    g = 0;
    step(1'b0);
    while (m_duty != 7 && g < 100) begin step(1'b0); g++; end
    step(1'b1);
    @(posedge clk);
    #2 check("rev_state", int'(state_o), 3);
    check("rev_duty", int'(duty_o), 7);
    g = 0;
    while (m_state != 0 && g < 100) begin step(1'b1); g++; end

    // Drop the request in the same cycle the duty reaches its maximum
    g = 0;
    step(1'b0);
    while (!(m_state == 1 && m_duty == DM) && g < 100) begin step(1'b0); g++; end
    step(1'b1);
    @(posedge clk);
    #2 check("simul_state", int'(state_o), 3);
    g = 0;
    while (m_state != 0 && g < 100) begin step(1'b1); g++; end

    // Reset mid-ramp, then restart from duty 0 with the request held
    repeat (22) step(1'b0);
    async_reset("mid_rst");
    repeat (70) step(1'b0);

    // Random request runs, both slow and faster than the step timer
    repeat (60) begin
      l = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 80);
      repeat (n) step(l);
    end

    @(posedge clk);
    #3 check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
